// File: rtl/cic_comb_seq.sv
// Time-multiplexed CIC comb section: one subtractor walks STAGES cascaded
// differentiators, one stage per clock, with per-channel per-stage delay lines.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_ready is high only while idle. A sample offered while busy is dropped and
// sets the sticky overrun flag. Samples whose channel index is out of range
// are ignored outright. out_valid is a single-cycle strobe; out_data/out_ch
// keep their value between strobes.
module cic_comb_seq #(
  parameter int WIDTH      = 24,
  parameter int STAGES     = 3,
  parameter int DIFF_DELAY = 1,
  parameter int CHANNELS   = 2,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(STAGES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CH_W-1:0]  ch;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    s;

  // Delay memory: [channel][stage][tap]; tap 0 is the most recent value.
  logic [WIDTH-1:0] dly [CHANNELS][STAGES][DIFF_DELAY];

  logic             ch_ok;
  logic [WIDTH-1:0] dly_tap;
  logic [WIDTH-1:0] y;
  logic             run_step;

  assign in_ready = (state == ST_IDLE);
  assign ch_ok    = (32'(in_ch) < CHANNELS);
  assign run_step = (state == ST_RUN) && !flush;

  // Select the oldest tap of the active (channel, stage) and form the difference.
  always_comb begin
    dly_tap = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < STAGES; i++) begin
        if (ch == c[CH_W-1:0] && s == i[SW-1:0]) begin
          dly_tap = dly[c][i][DIFF_DELAY-1];
        end
      end
    end
    // Modulo 2^WIDTH wrap is intentional: the integrators upstream rely on it.
    y = acc - dly_tap;
  end

  // Delay memory update: shift the stage input into the active delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < STAGES; i++)
          for (int k = 0; k < DIFF_DELAY; k++)
            dly[c][i][k] <= '0;
    end else if (flush) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < STAGES; i++)
          for (int k = 0; k < DIFF_DELAY; k++)
            dly[c][i][k] <= '0;
    end else if (run_step) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int i = 0; i < STAGES; i++) begin
          if (ch == c[CH_W-1:0] && s == i[SW-1:0]) begin
            for (int k = DIFF_DELAY - 1; k > 0; k--)
              dly[c][i][k] <= dly[c][i][k-1];
            dly[c][i][0] <= acc;
          end
        end
      end
    end
  end

  // Control FSM, stage sequencing, result register and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      acc       <= '0;
      s         <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      // A drop always wins over a simultaneous clear. This also covers a
      // sample offered in the same cycle a flush aborts a running sample.
      if (in_valid && !in_ready && ch_ok) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end

      if (flush) begin
        state <= ST_IDLE;
        s     <= '0;
      end else if (state == ST_IDLE) begin
        if (in_valid && ch_ok) begin
          ch    <= in_ch;
          acc   <= in_data;
          s     <= '0;
          state <= ST_RUN;
        end
      end else begin
        acc <= y;
        if (s == S_LAST) begin
          out_data  <= y;
          out_ch    <= ch;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
          s         <= '0;
        end else begin
          s <= s + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_seq.sv
// Bench for cic_comb_seq: instance A (3 stages, M=1, 3 channels) and
// instance B (1 stage, M=2, 1 channel). The reference model evaluates the
// comb transfer function (1 - z^-M)^S as a binomial sum over input history.
module tb_cic_comb_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_flush, a_overrun, a_ovr_clr;
  logic [1:0]  a_in_ch, a_out_ch;
  logic [23:0] a_in_data, a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_flush, b_overrun, b_ovr_clr;
  logic [0:0]  b_in_ch, b_out_ch;
  logic [23:0] b_in_data, b_out_data;

  cic_comb_seq #(.WIDTH(24), .STAGES(3), .DIFF_DELAY(1), .CHANNELS(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ch(a_in_ch), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ch(a_out_ch), .out_data(a_out_data), .flush(a_flush),
    .overrun(a_overrun), .ovr_clr(a_ovr_clr));

  cic_comb_seq #(.WIDTH(24), .STAGES(1), .DIFF_DELAY(2), .CHANNELS(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ch(b_in_ch), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ch(b_out_ch), .out_data(b_out_data), .flush(b_flush),
    .overrun(b_overrun), .ovr_clr(b_ovr_clr));

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_q[$];

  // Model history: slots 0..2 are instance A channels, slot 3 is instance B.
  logic [23:0] hist [4][512];
  int          cnt [4];

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int j = 0; j < k; j++) r = r * (n - j) / (j + 1);
    return r;
  endfunction

  function automatic logic [23:0] model_step(input int mc, input int st, input int m,
                                             input logic [23:0] x);
    logic [31:0] sum;
    int idx;
    if (cnt[mc] < 512) begin
      hist[mc][cnt[mc]] = x;
      cnt[mc]++;
    end
    sum = 32'd0;
    for (int k = 0; k <= st; k++) begin
      idx = cnt[mc] - 1 - k * m;
      if (idx >= 0) begin
        if (k % 2 == 1) sum = sum - 32'(binom(st, k)) * {8'd0, hist[mc][idx]};
        else            sum = sum + 32'(binom(st, k)) * {8'd0, hist[mc][idx]};
      end
    end
    return sum[23:0];
  endfunction

  task automatic model_clear_all;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  // ---------------- driver tasks (no checking inside) ----------------
  task automatic send_a(input logic [1:0] ch, input logic [23:0] d, output logic got,
                        output logic [23:0] od, output logic [1:0] oc, output int lat);
    int t = 0;
    while (!a_in_ready && t < 20) begin @(negedge clk); t++; end
    a_in_valid = 1'b1; a_in_ch = ch; a_in_data = d;
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
    got = a_out_valid; od = a_out_data; oc = a_out_ch;
  endtask

  task automatic send_b(input logic [23:0] d, output logic got, output logic [23:0] od,
                        output int lat);
    int t = 0;
    while (!b_in_ready && t < 20) begin @(negedge clk); t++; end
    b_in_valid = 1'b1; b_in_ch = 1'b0; b_in_data = d;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin @(negedge clk); lat++; end
    got = b_out_valid; od = b_out_data;
  endtask

  task automatic flush_a;
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
  endtask

  task automatic watch_a(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear_all();
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 24'd0 || a_out_ch !== 2'd0) begin failures++; $display("FAIL reset_out got=%h/%0d exp=0/0", a_out_data, a_out_ch); end
    checks++; if (a_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", a_overrun); end
    checks++; if (b_in_ready !== 1'b1 || b_out_data !== 24'd0) begin failures++; $display("FAIL reset_b got=%b/%h exp=1/0", b_in_ready, b_out_data); end
  endtask

  task automatic test_impulse;
    logic [23:0] exp_t [6] = '{24'd1, 24'hFFFFFD, 24'd3, 24'hFFFFFF, 24'd0, 24'd0};
    logic got; logic [23:0] od; logic [1:0] oc; int lat;
    flush_a();
    for (int i = 0; i < 6; i++) begin
      send_a(2'd0, (i == 0) ? 24'd1 : 24'd0, got, od, oc, lat);
      checks++; if (got !== 1'b1 || od !== exp_t[i] || oc !== 2'd0) begin failures++; $display("FAIL impulse[%0d] got=%b/%h/%0d exp=1/%h/0", i, got, od, oc, exp_t[i]); end
      if (i == 0) begin
        checks++; if (lat !== 4 || a_in_ready !== 1'b1) begin failures++; $display("FAIL latency got=%0d ready=%b exp=4 ready=1", lat, a_in_ready); end
      end
    end
  endtask

  task automatic test_constant;
    logic [23:0] exp_t [6] = '{24'd5, 24'hFFFFF6, 24'd5, 24'd0, 24'd0, 24'd0};
    logic got; logic [23:0] od; logic [1:0] oc; int lat;
    flush_a();
    for (int i = 0; i < 6; i++) begin
      send_a(2'd0, 24'd5, got, od, oc, lat);
      checks++; if (got !== 1'b1 || od !== exp_t[i]) begin failures++; $display("FAIL constant[%0d] got=%b/%h exp=1/%h", i, got, od, exp_t[i]); end
    end
  endtask

  task automatic test_interleave;
    logic [23:0] imp_t [6] = '{24'd1, 24'hFFFFFD, 24'd3, 24'hFFFFFF, 24'd0, 24'd0};
    logic [23:0] con_t [6] = '{24'd5, 24'hFFFFF6, 24'd5, 24'd0, 24'd0, 24'd0};
    logic got; logic [23:0] od; logic [1:0] oc; int lat;
    flush_a();
    for (int i = 0; i < 6; i++) begin
      send_a(2'd0, (i == 0) ? 24'd1 : 24'd0, got, od, oc, lat);
      checks++; if (got !== 1'b1 || od !== imp_t[i] || oc !== 2'd0) begin failures++; $display("FAIL interleave_ch0[%0d] got=%h/%0d exp=%h/0", i, od, oc, imp_t[i]); end
      send_a(2'd1, 24'd5, got, od, oc, lat);
      checks++; if (got !== 1'b1 || od !== con_t[i] || oc !== 2'd1) begin failures++; $display("FAIL interleave_ch1[%0d] got=%h/%0d exp=%h/1", i, od, oc, con_t[i]); end
    end
  endtask

  task automatic test_random;
    logic got; logic [23:0] od, d, e; logic [1:0] oc, ch; int lat;
    flush_a();
    for (int i = 0; i < 40; i++) begin
      ch = 2'($urandom_range(0, 2));
      d  = 24'($urandom);
      e  = model_step(int'(ch), 3, 1, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_a(ch, d, got, od, oc, lat);
      checks++; if (got !== 1'b1 || od !== e || oc !== ch) begin failures++; $display("FAIL random[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, got, od, oc, e, ch); end
    end
  endtask

  task automatic test_invalid_ch;
    int seen, t; logic [23:0] e;
    flush_a();
    a_in_valid = 1'b1; a_in_ch = 2'd3; a_in_data = 24'd123;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL invalid_ch_accepted ready=%b exp=1", a_in_ready); end
    watch_a(6, seen);
    checks++; if (seen !== 0) begin failures++; $display("FAIL invalid_ch_out got=%0d strobes exp=0", seen); end
    // Out-of-range channel while busy must not flag overrun.
    e = model_step(0, 3, 1, 24'd9);
    a_in_valid = 1'b1; a_in_ch = 2'd0; a_in_data = 24'd9;
    @(negedge clk);
    a_in_ch = 2'd3; a_in_data = 24'd77;
    @(negedge clk);
    a_in_valid = 1'b0;
    t = 0;
    while (!a_out_valid && t < 20) begin @(negedge clk); t++; end
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== e) begin failures++; $display("FAIL invalid_ch_busy_out got=%b/%h exp=1/%h", a_out_valid, a_out_data, e); end
    checks++; if (a_overrun !== 1'b0) begin failures++; $display("FAIL invalid_ch_overrun got=%b exp=0", a_overrun); end
  endtask

  task automatic test_overrun;
    int outs = 0, t; logic [23:0] e, gotv;
    flush_a();
    exp_q.delete();
    // in_valid held high: accepted only every STAGES+1 cycles.
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (a_out_valid) begin
        outs++;
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL overrun_extra_out got=%h exp=none", a_out_data);
        end else begin
          gotv = exp_q.pop_front();
          checks++; if (a_out_data !== gotv) begin failures++; $display("FAIL overrun_out got=%h exp=%h", a_out_data, gotv); end
        end
      end
      if (cyc < 12) begin
        a_in_valid = 1'b1; a_in_ch = 2'd0; a_in_data = 24'(7 + 2 * cyc);
        if (cyc % 4 == 0) exp_q.push_back(model_step(0, 3, 1, 24'(7 + 2 * cyc)));
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (outs !== 3 || exp_q.size() !== 0) begin failures++; $display("FAIL overrun_count got=%0d left=%0d exp=3/0", outs, exp_q.size()); end
    checks++; if (a_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", a_overrun); end
    a_ovr_clr = 1'b1;
    @(negedge clk);
    a_ovr_clr = 1'b0;
    checks++; if (a_overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", a_overrun); end
    // Clear and new drop in the same cycle: set wins.
    e = model_step(0, 3, 1, 24'd50);
    a_in_valid = 1'b1; a_in_data = 24'd50;
    @(negedge clk);
    a_in_data = 24'd51; a_ovr_clr = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_ovr_clr = 1'b0;
    checks++; if (a_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set_wins got=%b exp=1", a_overrun); end
    t = 0;
    while (!a_out_valid && t < 20) begin @(negedge clk); t++; end
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== e) begin failures++; $display("FAIL overrun_after got=%b/%h exp=1/%h", a_out_valid, a_out_data, e); end
    a_ovr_clr = 1'b1;
    @(negedge clk);
    a_ovr_clr = 1'b0;
  endtask

  task automatic test_flush;
    int seen; logic got; logic [23:0] od; logic [1:0] oc; int lat;
    logic [23:0] imp_t [4] = '{24'd1, 24'hFFFFFD, 24'd3, 24'hFFFFFF};
    flush_a();
    a_in_valid = 1'b1; a_in_ch = 2'd0; a_in_data = 24'd1000;
    @(negedge clk);
    a_in_valid = 1'b0;
    flush_a();
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_run_idle ready=%b exp=1", a_in_ready); end
    watch_a(6, seen);
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_run_out got=%0d strobes exp=0", seen); end
    for (int i = 0; i < 4; i++) begin
      send_a(2'd0, (i == 0) ? 24'd1 : 24'd0, got, od, oc, lat);
      checks++; if (got !== 1'b1 || od !== imp_t[i]) begin failures++; $display("FAIL flush_restart[%0d] got=%b/%h exp=1/%h", i, got, od, imp_t[i]); end
    end
    // Flush with in_valid in IDLE: not accepted, and ch1 memory is cleared.
    send_a(2'd1, 24'd5, got, od, oc, lat);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_ch = 2'd1; a_in_data = 24'd5;
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_accept ready=%b exp=1", a_in_ready); end
    watch_a(6, seen);
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_idle_out got=%0d strobes exp=0", seen); end
    send_a(2'd1, 24'd5, got, od, oc, lat);
    checks++; if (got !== 1'b1 || od !== 24'd5) begin failures++; $display("FAIL flush_mem_clear got=%b/%h exp=1/000005", got, od); end
  endtask

  task automatic test_rst_mid;
    int seen; logic got; logic [23:0] od; logic [1:0] oc; int lat;
    logic [23:0] imp_t [4] = '{24'd1, 24'hFFFFFD, 24'd3, 24'hFFFFFF};
    flush_a();
    send_a(2'd1, 24'd77, got, od, oc, lat);
    a_in_valid = 1'b1; a_in_ch = 2'd0; a_in_data = 24'd1;
    @(negedge clk);
    a_in_data = 24'd2;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_overrun !== 1'b1 || a_out_data !== 24'd77) begin failures++; $display("FAIL rst_precond got=%b/%h exp=1/00004d", a_overrun, a_out_data); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear_all();
    checks++; if (a_out_data !== 24'd0 || a_out_ch !== 2'd0 || a_overrun !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_state got=%h/%0d/%b/%b exp=0/0/0/1", a_out_data, a_out_ch, a_overrun, a_in_ready);
    end
    watch_a(6, seen);
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_out got=%0d strobes exp=0", seen); end
    for (int i = 0; i < 4; i++) begin
      send_a(2'd0, (i == 0) ? 24'd1 : 24'd0, got, od, oc, lat);
      checks++; if (got !== 1'b1 || od !== imp_t[i]) begin failures++; $display("FAIL rst_restart[%0d] got=%b/%h exp=1/%h", i, got, od, imp_t[i]); end
    end
  endtask

  task automatic test_wrap_m2;
    logic [23:0] in_t [3] = '{24'h7FFFFF, 24'h000000, 24'h800000};
    logic [23:0] ex_t [3] = '{24'h7FFFFF, 24'h000000, 24'h000001};
    logic got; logic [23:0] od, d, e; int lat;
    for (int i = 0; i < 3; i++) begin
      void'(model_step(3, 1, 2, in_t[i]));
      send_b(in_t[i], got, od, lat);
      checks++; if (got !== 1'b1 || od !== ex_t[i]) begin failures++; $display("FAIL wrap_m2[%0d] got=%b/%h exp=1/%h", i, got, od, ex_t[i]); end
      if (i == 0) begin
        checks++; if (lat !== 2) begin failures++; $display("FAIL latency_b got=%0d exp=2", lat); end
      end
    end
    for (int i = 0; i < 20; i++) begin
      d = 24'($urandom);
      e = model_step(3, 1, 2, d);
      send_b(d, got, od, lat);
      checks++; if (got !== 1'b1 || od !== e) begin failures++; $display("FAIL random_m2[%0d] got=%b/%h exp=1/%h", i, got, od, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_ch = 2'd0; a_in_data = 24'd0; a_flush = 1'b0; a_ovr_clr = 1'b0;
    b_in_valid = 1'b0; b_in_ch = 1'b0; b_in_data = 24'd0; b_flush = 1'b0; b_ovr_clr = 1'b0;
    test_reset();
    test_impulse();
    test_constant();
    test_interleave();
    test_random();
    test_invalid_ch();
    test_overrun();
    test_flush();
    test_rst_mid();
    test_wrap_m2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
